dbg_fifo_ctrl: RTL
==================

# dbg_fifo_ctrl

Controller for the 32-entry debug-display log FIFO behind the 7-segment display. Two requesters share the FIFO write port through a round-robin arbiter: the CPU MMIO debug register and the hardware trap/event logger. The block also tracks how many entries are valid and drives the FIFO read address from debounced browse buttons. When new writes shift the FIFO, the browse cursor follows the entry the user is viewing, and a valid flag tells the display when the FIFO read data is current.

## Interface
Parameters:
- DEPTH, 32: FIFO depth; must match the FIFO instance.
- AW, $clog2(DEPTH) = 5: index width.

Ports:
- clk  in  1: system clock; the single clock.
- rst  in  1: reset; synchronous, active-high.
- a_req / a_data  in  1 / 32: CPU write request and data. Held until granted.
- a_gnt  out  1: combinational grant to A in the accepting cycle.
- b_req / b_data  in  1 / 32: event-logger write request and data. Held until granted.
- b_gnt  out  1: combinational grant to B.
- fifo_wea  out  1: FIFO write enable; equals a_gnt | b_gnt.
- fifo_din  out  32: data of the granted requester; 0 when no grant.
- fifo_addr  out  AW: registered read address; equals the cursor idx.
- fifo_dout  in  32: FIFO registered read data.
- btn_next / btn_prev / btn_latest  in  1: single-cycle browse pulses (older / newer / newest).
- disp_data  out  32: fifo_dout passthrough.
- disp_idx  out  AW: current cursor. 0 is the newest entry.
- disp_valid  out  1: disp_data matches entry disp_idx.
- disp_lost  out  1: sticky flag; the viewed entry was shifted out of the FIFO.
- count  out  AW+1: number of valid entries, 0..DEPTH.

## Operation
- Arbitration:
  - At most one grant per cycle.
  - Priority pointer reg `pri`: 0 means A is preferred, 1 means B is preferred.
  - With a single requester, that requester is granted.
  - With both requesting, the preferred one is granted; `pri` then flips to the loser.
  - `pri` is unchanged when there is no contention.
- count: increments on each fifo_wea and saturates at DEPTH. It never decrements except on rst.
- Cursor update, applied in this order within one cycle (w = fifo_wea):
  1. Shift: if w and idx != 0, then idx+1. If idx == DEPTH-1, idx holds at DEPTH-1 and disp_lost is set. An idx of 0 stays 0, so the display keeps showing the newest entry.
  2. Buttons (using count_next):
     - btn_latest: idx = 0. Overrides next/prev.
     - btn_next and btn_prev both asserted: ignored.
     - btn_next: idx+1; wraps to 0 when idx+1 >= count_next.
     - btn_prev: idx-1; wraps to count_next-1 when idx == 0.
     - count_next == 0: idx stays 0 for any button.
  3. Any button pulse that is not ignored clears disp_lost.
- FSM states SETTLE and SHOW:
  - Any cycle with w, or with a change in the registered idx, sets the state to SETTLE on the next edge.
  - Otherwise SETTLE advances to SHOW and SHOW holds.
  - disp_valid = (state == SHOW).
- Reset values: a_gnt = b_gnt = fifo_wea = 0, fifo_din = 0, fifo_addr = idx = 0, count = 0, pri = 0 (A preferred), disp_lost = 0, state = SETTLE, disp_valid = 0.

## Timing
- Grants are combinational from req and `pri`. The FIFO samples data at the same edge the grant is observed.
- Read path, where edge E0 registers a new idx or samples a write:
  - The FIFO samples the old address at E0 and the new address at E1.
  - The state is SETTLE between E0 and E1, and SHOW from E1 on.
  - disp_valid therefore rises 2 edges after the button pulse or write.
- Back-to-back writes keep the state in SETTLE, so disp_valid stays low throughout the burst.
- After rst deasserts, disp_valid rises one cycle later. disp_data is then the reset value 0 from the FIFO, with count = 0.
- A synchronous rst mid-burst drops grants in that same cycle and clears everything. Requesters must re-present held requests after reset.

## Test plan
- Reset, then 3 A-writes (0x11, 0x22, 0x33) -> count = 3, idx = 0, disp_valid high 2 cycles after the last write, disp_data = 0x33.
- A and B both requesting for 4 cycles (a_data = 0xA, b_data = 0xB) -> fifo_din sequence 0xA, 0xB, 0xA, 0xB; exactly one grant per cycle; count = 4.
- Browse wrap with count = 3:
  - btn_next ×3 -> idx 1, 2, 0.
  - btn_prev at idx 0 -> idx 2.
  - btn_latest -> idx 0.
  - btn_next together with btn_prev -> no change.
- Follow on write: at idx = 2 with data 0x22, one write of 0x44 -> idx = 3, disp_data = 0x22 after SETTLE. At idx = 0, a write -> idx stays 0, disp_data = 0x44.
- Overflow loss: count = 32, idx = 31, one write -> idx = 31, disp_lost = 1. Next btn_latest -> disp_lost = 0, idx = 0.
- rst asserted during a write burst while idx = 5 -> next cycle all outputs at reset values, disp_valid = 0, count = 0.

Source files
------------

// File: rtl/dbg_fifo_ctrl.sv
// Debug log FIFO controller: round-robin write arbiter, valid-entry count, browse cursor and read-settle tracking.
// Grants are combinational; cursor/count/flags update at the edge; disp_valid rises 2 edges after a write or cursor move.
module dbg_fifo_ctrl #(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic [31:0]   a_data,
   output logic          a_gnt,
   input  logic          b_req,
   input  logic [31:0]   b_data,
   output logic          b_gnt,
   output logic          fifo_wea,
   output logic [31:0]   fifo_din,
   output logic [AW-1:0] fifo_addr,
   input  logic [31:0]   fifo_dout,
   input  logic          btn_next,
   input  logic          btn_prev,
   input  logic          btn_latest,
   output logic [31:0]   disp_data,
   output logic [AW-1:0] disp_idx,
   output logic          disp_valid,
   output logic          disp_lost,
   output logic [AW:0]   count
);

   typedef enum logic {SETTLE, SHOW} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_pri;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_idx;
   logic          r_lost;

   logic          w_a_gnt, w_b_gnt, w_wea;
   logic [AW:0]   w_count_nxt, w_cnt_m1, w_idx_p1;
   logic [AW-1:0] w_idx_sh, w_idx_nxt;
   logic          w_lost_nxt, w_btn_ok;

   // Grants are masked during reset so an in-flight burst is dropped in the reset cycle.
   assign w_a_gnt = ~rst & a_req & (~b_req | ~r_pri);
   assign w_b_gnt = ~rst & b_req & (~a_req | r_pri);
   assign w_wea   = w_a_gnt | w_b_gnt;

   assign a_gnt     = w_a_gnt;
   assign b_gnt     = w_b_gnt;
   assign fifo_wea  = w_wea;
   assign fifo_din  = w_a_gnt ? a_data : (w_b_gnt ? b_data : 32'd0);
   assign fifo_addr = r_idx;
   assign disp_idx  = r_idx;
   assign disp_data = fifo_dout;
   assign disp_lost = r_lost;
   assign count     = r_count;

   assign w_count_nxt = (w_wea && r_count != (AW+1)'(DEPTH)) ? r_count + 1'b1 : r_count;
   assign w_cnt_m1    = w_count_nxt - 1'b1;
   assign w_btn_ok    = btn_latest | (btn_next ^ btn_prev);

   always_comb begin
      w_idx_sh   = r_idx;
      w_lost_nxt = r_lost;
      // Follow the viewed entry as new writes push it deeper; the newest view stays at 0.
      if (w_wea && r_idx != '0) begin
         if (r_idx == AW'(DEPTH - 1)) w_lost_nxt = 1'b1;
         else                          w_idx_sh   = r_idx + 1'b1;
      end
      w_idx_p1  = {1'b0, w_idx_sh} + 1'b1;
      w_idx_nxt = w_idx_sh;
      if (btn_latest) begin
         w_idx_nxt = '0;
      end else if (btn_next ^ btn_prev) begin
         if (w_count_nxt == '0)
            w_idx_nxt = '0;
         else if (btn_next)
            w_idx_nxt = (w_idx_p1 >= w_count_nxt) ? '0 : w_idx_p1[AW-1:0];
         else
            w_idx_nxt = (w_idx_sh == '0) ? w_cnt_m1[AW-1:0] : w_idx_sh - 1'b1;
      end
      if (w_btn_ok) w_lost_nxt = 1'b0;
   end

   always_comb begin
      w_state_nxt = SHOW;
      disp_valid  = (r_state == SHOW);
      if (w_wea || w_idx_nxt != r_idx) w_state_nxt = SETTLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SETTLE;
         r_pri   <= 1'b0;
         r_count <= '0;
         r_idx   <= '0;
         r_lost  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (a_req && b_req) r_pri <= w_a_gnt;
         r_count <= w_count_nxt;
         r_idx   <= w_idx_nxt;
         r_lost  <= w_lost_nxt;
      end
   end

endmodule
